// File: rtl/div_32_seq_if.sv
// Request/response bundle between the pipeline control and the sequential divider.
// The master side issues divisions; the slave side is the divider itself.
interface div_32_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_32_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// sign correction in a final FIX cycle, results held for the HI/LO registers.
module div_32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  div_32_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;          // partial remainder, one guard bit
  logic [WIDTH-1:0] q_q, q_d;          // dividend magnitude shifting into quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             a_neg_in, b_neg_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // exactly its magnitude when read as unsigned.
  assign a_neg_in = bus.is_signed & bus.dividend[WIDTH-1];
  assign b_neg_in = bus.is_signed & bus.divisor[WIDTH-1];
  assign a_mag    = a_neg_in ? -bus.dividend : bus.dividend;
  assign b_mag    = b_neg_in ? -bus.divisor  : bus.divisor;

  assign shifted  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvs_q};

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  assign q_fix    = (signed_q & (a_neg_q ^ b_neg_q)) ? -q_q : q_q;
  assign r_fix    = (signed_q & a_neg_q) ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      r_q      <= '0;
      q_q      <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      q_q      <= q_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
    end
  end

  // NOTE: every signal driven here gets a hold default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    q_d      = q_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          signed_d = bus.is_signed;
          a_neg_d  = a_neg_in;
          b_neg_d  = b_neg_in;
          dvs_d    = b_mag;
          r_d      = '0;
          q_d      = a_mag;
          cnt_d    = '0;
          if (bus.divisor == '0) begin
            // Zero divisor skips iteration; result is fixed regardless of sign mode.
            quo_d   = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        r_d   = trial[WIDTH] ? shifted : trial;
        q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end
      end

      FIX: begin
        quo_d   = q_fix;
        rem_d   = r_fix;
        dbz_d   = 1'b0;
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

  done_is_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    bus.done |=> !bus.done);

endmodule
